// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the serial pattern generator and for
// benches that detect the patterns it emits.
//   state_t   - FSM state encoding (IDLE, SEND, DONE)
//   MAX_W     - widest pattern the border helper supports
//   border()  - length of the longest proper suffix of a pattern that
//               equals its prefix (0..w-1)
package seq_pkg;

  localparam int MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // p holds the pattern in its low w bits, MSB first.
  // Longer candidates are tried later, so the last match wins.
  function automatic logic [3:0] border(input logic [MAX_W-1:0] p, input int w);
    logic [3:0] b;
    logic       ok;
    b = '0;
    for (int k = 1; k < MAX_W; k++) begin
      if (k < w) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_W; i++)
          if (i < k && p[w-k+i] != p[i]) ok = 1'b0;
        if (ok) b = 4'(k);
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/seq_gen_if.sv
// seq_gen_if: burst request / serial output bundle for seq_gen.
//   start, pattern, count, overlap : burst request (master -> slave)
//   dout, dvalid, busy, done       : serial stream and status (slave -> master)
interface seq_gen_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] count;
  logic             overlap;
  logic             dout;
  logic             dvalid;
  logic             busy;
  logic             done;

  modport master (output start, pattern, count, overlap,
                  input  dout, dvalid, busy, done);
  modport slave  (input  start, pattern, count, overlap,
                  output dout, dvalid, busy, done);
endinterface

// File: rtl/seq_gen.sv
// seq_gen: emits `count` repetitions of `pattern` MSB first on dout. With
// overlap set, every repetition after the first skips the leading k bits
// that are already present as the previous copy's border.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - seq_gen_if.slave (request in, dout/dvalid/busy/done out)
module seq_gen
  import seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic     clk,
  input  logic     rst,
  seq_gen_if.slave bus
);

  localparam int IDX_W = $clog2(WIDTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] pat, pat_n;
  logic [3:0]       kreg, k_n;
  logic [IDX_W-1:0] idx, idx_n;   // bit of pat currently on dout
  logic [CNT_W-1:0] rep, rep_n;   // repetitions left, including current

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pat   <= '0;
      kreg  <= '0;
      idx   <= '0;
      rep   <= '0;
    end else begin
      state <= state_n;
      pat   <= pat_n;
      kreg  <= k_n;
      idx   <= idx_n;
      rep   <= rep_n;
    end
  end

  always_comb begin
    state_n = state;
    pat_n   = pat;
    k_n     = kreg;
    idx_n   = idx;
    rep_n   = rep;
    case (state)
      IDLE: if (bus.start) begin
        pat_n   = bus.pattern;
        rep_n   = bus.count;
        k_n     = bus.overlap ? border(MAX_W'(bus.pattern), WIDTH) : 4'd0;
        idx_n   = IDX_W'(WIDTH-1);
        state_n = (bus.count == '0) ? DONE : SEND;
      end
      SEND: begin
        if (idx == '0) begin
          if (rep == CNT_W'(1)) state_n = DONE;
          else begin
            rep_n = rep - CNT_W'(1);
            // next copy resumes just past the shared border
            idx_n = IDX_W'(WIDTH-1-int'(kreg));
          end
        end else begin
          idx_n = idx - IDX_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs depend only on registered state.
  assign bus.dvalid = (state == SEND);
  assign bus.dout   = (state == SEND) ? pat[idx] : 1'b0;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_seq_gen.sv
module tb_seq_gen;
  localparam int W  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_gen_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  seq_gen #(.WIDTH(W), .CNT_W(CW)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_border(input int p);
    for (int k = W-1; k >= 1; k--)
      if ((p >> (W-k)) == (p & ((1 << k) - 1))) return k;
    return 0;
  endfunction

  // Expected bit stream built straight from the repetition rule.
  function automatic void ref_stream(input int p, input int c, input bit o, ref bit q[$]);
    int k;
    q.delete();
    k = o ? ref_border(p) : 0;
    if (c == 0) return;
    for (int b = W-1; b >= 0; b--) q.push_back(p[b]);
    for (int r = 2; r <= c; r++)
      for (int b = W-1-k; b >= 0; b--) q.push_back(p[b]);
  endfunction

  function automatic int hits1001(input logic [63:0] s, input int n);
    int h = 0;
    for (int i = 0; i + 4 <= n; i++)
      if (((s >> (n-4-i)) & 64'hf) == 64'h9) h++;
    return h;
  endfunction

  logic [63:0] cap;
  int          cap_n;

  // Issue one burst and check every cycle from the first bit to the IDLE
  // cycle after done. Request inputs are scrambled during the burst.
  task automatic do_burst(input int p, input int c, input bit o, input string tag);
    bit q[$];
    int n;
    ref_stream(p, c, o, q);
    n = q.size();
    cap = '0; cap_n = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.pattern = W'(p); bus.count = CW'(c); bus.overlap = o;
    @(negedge clk);
    for (int cyc = 0; cyc <= n + 1; cyc++) begin
      chk({tag, "_dvalid"}, 64'(bus.dvalid), 64'(cyc < n));
      chk({tag, "_dout"},   64'(bus.dout),   64'((cyc < n) ? q[cyc] : 1'b0));
      chk({tag, "_busy"},   64'(bus.busy),   64'(cyc <= n));
      chk({tag, "_done"},   64'(bus.done),   64'(cyc == n));
      if (bus.dvalid) begin cap = {cap[62:0], bus.dout}; cap_n++; end
      if (cyc < n) begin
        bus.start   = 1'($urandom);
        bus.pattern = W'($urandom);
        bus.count   = CW'($urandom);
        bus.overlap = 1'($urandom);
      end else bus.start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dvalid"}, 64'(bus.dvalid), 64'd0);
    chk({tag, "_dout"},   64'(bus.dout),   64'd0);
    chk({tag, "_busy"},   64'(bus.busy),   64'd0);
    chk({tag, "_done"},   64'(bus.done),   64'd0);
  endtask

  initial begin
    bit q[$];
    int n;
    bus.start = 1'b0; bus.pattern = '0; bus.count = '0; bus.overlap = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    do_burst(4'b1001, 3, 1'b0, "r029");
    chk("r029_len", 64'(cap_n), 64'd12);
    chk("r029_bits", cap, 64'b100110011001);

    do_burst(4'b1001, 3, 1'b1, "r030");
    chk("r030_len", 64'(cap_n), 64'd10);
    chk("r030_bits", cap, 64'b1001001001);
    chk("r030_hits", 64'(hits1001(cap, cap_n)), 64'd3);

    do_burst(4'b1111, 3, 1'b1, "r031a");
    chk("r031a_bits", cap, 64'b111111);
    chk("r031a_len", 64'(cap_n), 64'd6);
    do_burst(4'b1000, 3, 1'b1, "r031b");
    chk("r031b_bits", cap, 64'b100010001000);

    do_burst(4'b1010, 0, 1'b1, "r032");
    do_burst(4'b0110, 15, 1'b0, "maxcnt");
    chk("maxcnt_len", 64'(cap_n), 64'd60);

    // reset on the 5th bit of a burst
    ref_stream(4'b1011, 5, 1'b0, q);
    @(negedge clk);
    bus.start = 1'b1; bus.pattern = 4'b1011; bus.count = 5; bus.overlap = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      chk("r033_pre_dout", 64'(bus.dout), 64'(q[cyc]));
      if (cyc == 4) rst = 1'b1;
      @(negedge clk);
    end
    chk_idle("r033_rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("r033_nostart");
    do_burst(4'b1011, 5, 1'b0, "r033_after");

    // start held high: burst, DONE, IDLE, next burst
    ref_stream(4'b1101, 2, 1'b1, q);
    n = q.size();
    @(negedge clk);
    bus.start = 1'b1; bus.pattern = 4'b1101; bus.count = 2; bus.overlap = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc <= n + 2; cyc++) begin
      chk("r034_dvalid", 64'(bus.dvalid), 64'(cyc < n || cyc == n + 2));
      chk("r034_dout", 64'(bus.dout),
          64'((cyc < n) ? q[cyc] : (cyc == n + 2) ? 1'b1 : 1'b0));
      chk("r034_done", 64'(bus.done), 64'(cyc == n));
      chk("r034_busy", 64'(bus.busy), 64'(cyc != n + 1));
      @(negedge clk);
    end
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("r034_clean");

    for (int t = 0; t < 30; t++)
      do_burst(int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom), "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
